// File: rtl/sigmoid_arbiter_if.sv
// Request, sigmoid-unit and response bundle for sigmoid_arbiter.
// slave: arbiter side; master: neuron array plus activation unit side.
interface sigmoid_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 17
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_x;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         sig_x;
  logic                      sig_x_valid;
  logic [DATA_W-1:0]         sig_y;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_y;
  logic                      busy;

  modport slave (
    input  req_valid,
    input  req_x,
    input  sig_y,
    output req_ready,
    output sig_x,
    output sig_x_valid,
    output rsp_valid,
    output rsp_y,
    output busy
  );

  modport master (
    output req_valid,
    output req_x,
    output sig_y,
    input  req_ready,
    input  sig_x,
    input  sig_x_valid,
    input  rsp_valid,
    input  rsp_y,
    input  busy
  );
endinterface

// File: rtl/sigmoid_arbiter.sv
// Round-robin share of one pipelined sigmoid unit among NUM_REQ
// requesters; results are routed back by a tag shift register.
module sigmoid_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 17,
  parameter int LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst,
  sigmoid_arbiter_if.slave bus
);
  localparam int IDW  = $clog2(NUM_REQ);
  localparam int LAST = LATENCY;

  logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]      sig_x_q, sig_x_d;
  logic                   sig_x_valid_q, sig_x_valid_d;
  logic [LAST:0]          tag_v_q, tag_v_d;
  logic [LAST:0][IDW-1:0] tag_id_q, tag_id_d;
  logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]      rsp_y_q, rsp_y_d;

  logic [DATA_W-1:0]  x_arr [NUM_REQ];
  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gnt_id;
  logic [IDW-1:0]     idx;
  logic               fire;
  int                 s;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      x_arr[i] = bus.req_x[i*DATA_W +: DATA_W];
    end
  end

  // Scan from rr_ptr, wrapping; first pending requester wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    fire   = 1'b0;
    idx    = '0;
    s      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s = int'(rr_ptr_q) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      idx = IDW'(s);
      if (!fire && !rst && bus.req_valid[idx]) begin
        fire     = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    sig_x_d       = sig_x_q;
    sig_x_valid_d = fire;
    if (fire) begin
      sig_x_d = x_arr[gnt_id];
      if (gnt_id == IDW'(NUM_REQ-1)) rr_ptr_d = '0;
      else                           rr_ptr_d = gnt_id + 1'b1;
    end
    tag_v_d     = {tag_v_q[LAST-1:0], fire};
    tag_id_d[0] = gnt_id;
    for (int i = 1; i <= LAST; i++) begin
      tag_id_d[i] = tag_id_q[i-1];
    end
    rsp_valid_d = '0;
    rsp_y_d     = rsp_y_q;
    if (tag_v_q[LAST]) begin
      rsp_valid_d[tag_id_q[LAST]] = 1'b1;
      rsp_y_d                     = bus.sig_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q      <= '0;
      sig_x_q       <= '0;
      sig_x_valid_q <= 1'b0;
      tag_v_q       <= '0;
      tag_id_q      <= '0;
      rsp_valid_q   <= '0;
      rsp_y_q       <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      sig_x_q       <= sig_x_d;
      sig_x_valid_q <= sig_x_valid_d;
      tag_v_q       <= tag_v_d;
      tag_id_q      <= tag_id_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_y_q       <= rsp_y_d;
    end
  end

  assign bus.req_ready   = gnt;
  assign bus.sig_x       = sig_x_q;
  assign bus.sig_x_valid = sig_x_valid_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_y       = rsp_y_q;
  assign bus.busy        = (|tag_v_q) | sig_x_valid_q;
endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Directed and random bench for sigmoid_arbiter with a
// x+1 sigmoid stand-in and a response scoreboard.
module tb_sigmoid_arbiter;
  localparam int N = 4;
  localparam int W = 17;
  localparam int L = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sigmoid_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

  sigmoid_arbiter #(
    .NUM_REQ(N),
    .DATA_W (W),
    .LATENCY(L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [W-1:0] sp [L];
  always @(posedge clk) begin
    sp[0] <= bus.sig_x_valid ? bus.sig_x + 1'b1 : 17'h15A5A;
    for (int i = 1; i < L; i++) sp[i] <= sp[i-1];
  end
  assign bus.sig_y = sp[L-1];

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] y;
  } exp_t;
  exp_t sb [$];

  always @(posedge clk) begin
    exp_t e;
    if (bus.rsp_valid != '0) begin
      check("rsp_onehot", $countones(bus.rsp_valid), 1);
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'(bus.rsp_valid), 0);
      end else begin
        e = sb.pop_front();
        check("rsp_dest", 32'(bus.rsp_valid), 32'(1) << e.id);
        check("rsp_y", 32'(bus.rsp_y), 32'(e.y));
      end
    end
    check("idle_grant", 32'(bus.req_ready & ~bus.req_valid), 0);
    if (rst) begin
      sb.delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          e.id = 2'(i);
          e.y  = bus.req_x[i*W +: W] + 1'b1;
          sb.push_back(e);
        end
      end
    end
  end

  typedef struct {
    logic [N-1:0] rv;
    logic [N-1:0] rdy;
  } vec_t;
  vec_t tbl [20];

  logic         pv;
  logic [W-1:0] px;
  logic [N-1:0] pend;
  logic [W-1:0] rx [N];
  int           wt [N];

  initial begin
    for (int k = 0; k < 8; k++) begin
      tbl[k].rv  = 4'b1111;
      tbl[k].rdy = 4'b0001 << (k % 4);
    end
    tbl[8]  = '{4'b0100, 4'b0100};
    tbl[9]  = '{4'b1001, 4'b1000};
    tbl[10] = '{4'b1001, 4'b0001};
    tbl[11] = '{4'b0000, 4'b0000};
    tbl[12] = '{4'b0001, 4'b0001};
    tbl[13] = '{4'b1110, 4'b0010};
    tbl[14] = '{4'b1100, 4'b0100};
    tbl[15] = '{4'b1000, 4'b1000};
    tbl[16] = '{4'b0010, 4'b0010};
    tbl[17] = '{4'b0011, 4'b0001};
    tbl[18] = '{4'b0010, 4'b0010};
    tbl[19] = '{4'b0000, 4'b0000};

    bus.req_valid = '0;
    bus.req_x     = '0;
    rst           = 1'b1;
    repeat (3) @(negedge clk);
    bus.req_valid = 4'b1111;
    #1;
    check("rst_ready", 32'(bus.req_ready), 0);
    check("rst_sxv", 32'(bus.sig_x_valid), 0);
    check("rst_sx", 32'(bus.sig_x), 0);
    check("rst_rspv", 32'(bus.rsp_valid), 0);
    check("rst_rspy", 32'(bus.rsp_y), 0);
    check("rst_busy", 32'(bus.busy), 0);

    pv = 1'b0;
    px = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      rst = 1'b0;
      bus.req_valid = tbl[k].rv;
      for (int i = 0; i < N; i++) bus.req_x[i*W +: W] = W'(k*16 + i);
      #1;
      check("tbl_grant", 32'(bus.req_ready), 32'(tbl[k].rdy));
      check("tbl_sxv", 32'(bus.sig_x_valid), 32'(pv));
      if (pv) check("tbl_sx", 32'(bus.sig_x), 32'(px));
      pv = (tbl[k].rdy != '0);
      for (int i = 0; i < N; i++) if (tbl[k].rdy[i]) px = W'(k*16 + i);
    end

    repeat (8) @(negedge clk);
    #1;
    check("drain_busy", 32'(bus.busy), 0);

    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      bus.req_valid = (c == 0) ? 4'b0100 : 4'b0000;
      bus.req_x[2*W +: W] = 17'h01000;
      #1;
      if (c == 0) check("one_ready", 32'(bus.req_ready), 32'h4);
      if (c == 1) check("one_sxv", 32'(bus.sig_x_valid), 1);
      if (c == 1) check("one_sx", 32'(bus.sig_x), 32'h01000);
      if (c == 2) check("one_sxv_low", 32'(bus.sig_x_valid), 0);
      check("one_busy", 32'(bus.busy), (c >= 1 && c <= 4) ? 1 : 0);
      check("one_rspv", 32'(bus.rsp_valid), (c == 5) ? 32'h4 : 0);
      if (c == 5) check("one_rspy", 32'(bus.rsp_y), 32'h01001);
    end

    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus.req_valid = (c < 3) ? 4'b0010 : 4'b0000;
      bus.req_x[1*W +: W] = W'(5 + c);
      #1;
      if (c < 3) check("re_ready", 32'(bus.req_ready), 32'h2);
      if (c >= 5) begin
        check("re_rspv", 32'(bus.rsp_valid), 32'h2);
        check("re_rspy", 32'(bus.rsp_y), 32'(c + 1));
      end else begin
        check("re_rspv_low", 32'(bus.rsp_valid), 0);
      end
    end

    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      rst = (c == 2);
      case (c)
        0:       bus.req_valid = 4'b0001;
        1:       bus.req_valid = 4'b0100;
        2:       bus.req_valid = 4'b1000;
        default: bus.req_valid = 4'b0000;
      endcase
      bus.req_x[0*W +: W] = 17'd100;
      bus.req_x[2*W +: W] = 17'd200;
      #1;
      if (c == 0) check("mr_ready0", 32'(bus.req_ready), 32'h1);
      if (c == 1) check("mr_ready1", 32'(bus.req_ready), 32'h4);
      if (c == 2) check("mr_ready_rst", 32'(bus.req_ready), 0);
      if (c == 3) begin
        check("mr_busy", 32'(bus.busy), 0);
        check("mr_sxv", 32'(bus.sig_x_valid), 0);
        check("mr_sx", 32'(bus.sig_x), 0);
      end
      if (c >= 3) check("mr_rspv", 32'(bus.rsp_valid), 0);
    end

    pend = '0;
    for (int i = 0; i < N; i++) begin
      rx[i] = '0;
      wt[i] = 0;
    end
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          pend[i] = 1'($urandom_range(0, 1));
          rx[i]   = W'($urandom);
        end
        bus.req_x[i*W +: W] = rx[i];
      end
      bus.req_valid = pend;
      #1;
      check("rnd_onehot", 32'($countones(bus.req_ready) <= 1), 1);
      for (int i = 0; i < N; i++) begin
        if (pend[i] && !bus.req_ready[i]) wt[i]++;
        else wt[i] = 0;
        check("rnd_starve", 32'(wt[i] <= N-1), 1);
      end
      pend = pend & ~bus.req_ready;
    end

    @(negedge clk);
    bus.req_valid = '0;
    repeat (12) @(negedge clk);
    #1;
    check("end_busy", 32'(bus.busy), 0);
    check("end_sb_empty", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sigmoid_arbiter.md
Name: sigmoid_arbiter

Overview:
- Shares one pipelined sigmoid evaluation unit among NUM_REQ neuron requesters.
- Round-robin arbiter accepts at most one operand per cycle and drives it onto the sigmoid unit input.
- Tags each issued operand with its requester index, carries the tag through a LATENCY-deep shift register, and routes the returned result back to the originating requester.
- Sits between the neuron array and the single shared activation unit.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_W, 17, operand/result width; signed fixed point, treated as opaque by this block.
- LATENCY, 3, fixed cycles from sig_x_valid to the matching sig_y on the sigmoid unit (1..8).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_x  in  NUM_REQ*DATA_W  packed operands; requester i in bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot grant; transfer on req_valid[i] & req_ready[i].
- sig_x  out  DATA_W  operand to sigmoid unit (registered).
- sig_x_valid  out  1  operand strobe to sigmoid unit (registered).
- sig_y  in  DATA_W  sigmoid unit result, valid LATENCY cycles after sig_x_valid.
- rsp_valid  out  NUM_REQ  one-hot result strobe, one cycle.
- rsp_y  out  DATA_W  result, broadcast to all requesters; qualified by rsp_valid.
- busy  out  1  high while any issued operand is still in flight.

Behaviour:
- Reset (rst=1 at clk edge): req_ready=0, sig_x=0, sig_x_valid=0, rsp_valid=0, rsp_y=0, busy=0, rr_ptr=0, tag pipeline cleared (all valid bits 0).
- req_ready is combinational from req_valid and rr_ptr.
  - Grant goes to the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - At most one bit of req_ready is set. req_ready=0 when no request is pending or rst=1.
- On a transfer from requester g:
  - sig_x<=req_x[g], sig_x_valid<=1 next cycle.
  - Tag stage 0 <= {valid=1, id=g}.
  - rr_ptr <= (g+1) mod NUM_REQ.
- Without a transfer: sig_x_valid<=0, sig_x holds, rr_ptr holds.
- Throughput is one issue per cycle and there is no backpressure from the sigmoid unit.
- A requester must hold req_valid and req_x until granted. The arbiter never grants a deasserted request.
- Tag pipeline: LATENCY+1 stages shift every cycle; the stage that aligns with sig_y is the last one.
  - When the last stage is valid with id=t: rsp_valid[t]<=1 and rsp_y<=sig_y, registered one cycle after sig_y.
  - Otherwise rsp_valid<=0 and rsp_y holds.
- Total latency from request handshake to rsp_valid is LATENCY+2 cycles.
- busy = OR of all tag-stage valid bits, plus sig_x_valid.
- Requester reissue: a requester may be granted again while its earlier operand is in flight. Responses return in issue order.
- Pointer wrap: rr_ptr advances from NUM_REQ-1 to 0.
- Single requester continuously valid: granted every cycle.
- Reset mid-operation: all in-flight tags are discarded and no rsp_valid is produced for them. sig_y arriving after reset is ignored.
- Simultaneous events: issuing in stage 0 and retiring from the last stage in the same cycle is legal and independent.

Test Plan:
- Reset, then req_valid=4'b1111 held for 8 cycles, NUM_REQ=4, LATENCY=3 -> grants in order 0,1,2,3,0,1,2,3; sig_x_valid high 8 consecutive cycles.
- req_valid=4'b0100, req_x[2]=17'h01000, sigmoid model returns x+1 -> req_ready=4'b0100 at cycle 0; sig_x_valid at cycle 1; rsp_valid=4'b0100 with rsp_y=17'h01001 at cycle 5; busy high cycles 1-4.
- rr_ptr=3, req_valid=4'b1001 -> grant 3 then 0; rr_ptr wraps to 0 then 1.
- Requester 1 issues x=5,6,7 on three consecutive cycles -> three rsp_valid[1] pulses, in order, with results f(5), f(6), f(7) on back-to-back cycles.
- Two operands in flight, rst pulsed for one cycle -> no rsp_valid for the following 6 cycles; busy=0 and req_ready=0 during reset.
- Full load for 100 cycles with random req_valid and the model checked against a scoreboard -> every accepted operand gets exactly one response to the correct requester; no grant to an idle requester; no requester starved more than NUM_REQ-1 cycles.
